wrap_event_ctrl: RTL
====================

# wrap_event_ctrl

Downstream consumer of the 4-bit free-running down counter. It samples the counter value every clock and detects each 0→F wrap-around. It counts wraps against a programmable period and raises an interrupt request with a req/ack handshake when the period completes. It also keeps a running event count and a sticky overrun flag for events lost while a request was still pending.

## Interface
Parameters:
- PERIOD_W, 8, width of period_cfg and the internal wrap counter
- EVT_W, 8, width of event_count

Ports:
- clk  in  1  rising-edge clock, same domain as the down counter
- reset  in  1  asynchronous, active-low reset
- count_in  in  4  current down-counter value
- enable  in  1  arms wrap counting; level-sensitive
- period_cfg  in  PERIOD_W  wraps per event minus one (0 → every wrap)
- irq_ack  in  1  acknowledge of irq_req
- clear_ovr  in  1  synchronous clear of overrun
- irq_req  out  1  event pending, held until acknowledged
- overrun  out  1  sticky: an event completed while irq_req was already high
- wrap_cnt  out  PERIOD_W  wraps seen in the current period
- event_count  out  EVT_W  total events generated, modulo 2^EVT_W
- state  out  2  FSM state: 00 IDLE, 01 ARMED, 10 PENDING

## Operation
- prev_count register holds count_in from the previous cycle. Reset value 4'hF.
- wrap = (prev_count == 4'h0) && (count_in == 4'hF). This is combinational in the cycle count_in shows F.
- A jump to F from any nonzero value is not a wrap, e.g. an upstream reset from 7 to F.
- A period completes on a wrap when enable=1 and wrap_cnt >= period_cfg.
  - On completion: wrap_cnt←0, event_count←event_count+1, and the event is delivered.
  - On a wrap that does not complete a period: wrap_cnt←wrap_cnt+1.
- `>=` compare: if period_cfg is lowered below wrap_cnt, the next wrap completes the period. period_cfg is used live, not latched.
- FSM:
  - IDLE: wrap_cnt held at 0. enable=1 → ARMED.
  - ARMED: counts wraps. Completion → PENDING with irq_req←1. enable=0 → IDLE with wrap_cnt←0.
  - PENDING: irq_req=1. Wrap counting continues while enable=1. On irq_ack=1 at a clock edge:
    - irq_req←0.
    - Next state is ARMED if enable=1, otherwise IDLE.
    - If enable=0, wrap_cnt←0.
  - enable=0 in PENDING does not drop irq_req. It is only cleared by ack.
- Completion in PENDING with irq_ack=0: overrun←1, irq_req stays 1, event_count still increments.
- Completion in PENDING with irq_ack=1 in the same cycle: irq_req stays 1 (new event), state stays PENDING, no overrun.
- clear_ovr=1 clears overrun. If an overrun condition occurs in the same cycle, set wins.
- event_count wraps FF→00 silently.
- Reset values: irq_req=0, overrun=0, wrap_cnt=0, event_count=0, state=IDLE, prev_count=F.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- Latency:
  - The cycle in which count_in=F follows count_in=0 is the wrap cycle.
  - wrap_cnt, event_count and irq_req update at the clock edge ending that cycle.
  - irq_req is visible one cycle after F appears on count_in.
- irq_ack is sampled only while irq_req=1. Ack while irq_req=0 is ignored.
- Minimum request pulse is 1 cycle: ack present in the first cycle irq_req is high drops it at the next edge.
- With the counter decrementing every cycle, a wrap occurs every 16 cycles. Events occur every 16·(period_cfg+1) cycles.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.
- The first wrap after reset release needs count_in to pass through 0. The reset value F of prev_count prevents a false wrap on an F→F start.

## Test plan
- Reset, enable=1, period_cfg=0, counter free-running from F:
  - irq_req rises 1 cycle after each F following 0 (every 16 cycles).
  - Acking each request in the first cycle keeps overrun=0.
- period_cfg=2, ack immediately:
  - wrap_cnt steps 0→1→2→0 on successive wraps.
  - irq_req fires every 48 cycles.
  - event_count = 3 after 144 cycles.
- period_cfg=0, never ack:
  - irq_req stays 1.
  - overrun=1 at the second wrap.
  - event_count keeps incrementing.
  - clear_ovr pulse → overrun=0 until the next wrap.
- Hold ack off until the cycle of the next completion, then assert irq_ack:
  - irq_req stays 1, overrun stays 0, state stays PENDING.
- Upstream counter reset pulsed while count_in=7 (jumps to F):
  - No wrap counted; wrap_cnt unchanged.
- Drop enable with wrap_cnt=1:
  - State goes to IDLE and wrap_cnt=0.
  - Drop enable in PENDING: irq_req stays high until ack, then state goes to IDLE.
  - Assert reset mid-PENDING: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/wrap_event_ctrl.sv
// Wrap-around event controller: detects 0->F wraps of an upstream 4-bit down
// counter, divides them by a programmable period and raises a req/ack interrupt.
module wrap_event_ctrl #(
    parameter int PERIOD_W = 8,
    parameter int EVT_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          count_in,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period_cfg,
    input  logic                irq_ack,
    input  logic                clear_ovr,
    output logic                irq_req,
    output logic                overrun,
    output logic [PERIOD_W-1:0] wrap_cnt,
    output logic [EVT_W-1:0]    event_count,
    output logic [1:0]          state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ARMED   = 2'b01,
        ST_PENDING = 2'b10
    } state_e;

    localparam logic [PERIOD_W-1:0] WRAP_ZERO = {PERIOD_W{1'b0}};
    localparam logic [PERIOD_W-1:0] WRAP_ONE  = {{(PERIOD_W-1){1'b0}}, 1'b1};
    localparam logic [EVT_W-1:0]    EVT_ZERO  = {EVT_W{1'b0}};
    localparam logic [EVT_W-1:0]    EVT_ONE   = {{(EVT_W-1){1'b0}}, 1'b1};

    state_e              state_q,       state_d;
    logic [3:0]          prev_count_q,  prev_count_d;
    logic [PERIOD_W-1:0] wrap_cnt_q,    wrap_cnt_d;
    logic [EVT_W-1:0]    event_count_q, event_count_d;
    logic                irq_req_q,     irq_req_d;
    logic                overrun_q,     overrun_d;
    logic                wrap_s;
    logic                complete_s;
    logic                ovr_set_s;

    // Wrap is only a genuine 0->F step; a jump to F from any other value is an upstream reset.
    assign wrap_s     = (prev_count_q == 4'h0) && (count_in == 4'hF);
    assign complete_s = wrap_s && enable && (wrap_cnt_q >= period_cfg);

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            prev_count_q  <= 4'hF;
            wrap_cnt_q    <= WRAP_ZERO;
            event_count_q <= EVT_ZERO;
            irq_req_q     <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            prev_count_q  <= prev_count_d;
            wrap_cnt_q    <= wrap_cnt_d;
            event_count_q <= event_count_d;
            irq_req_q     <= irq_req_d;
            overrun_q     <= overrun_d;
        end
    end

    // Next-state, wrap counting, event generation and overrun tracking.
    always_comb begin
        state_d       = state_q;
        prev_count_d  = count_in;
        wrap_cnt_d    = wrap_cnt_q;
        event_count_d = event_count_q;
        irq_req_d     = irq_req_q;
        ovr_set_s     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                wrap_cnt_d = WRAP_ZERO;
                irq_req_d  = 1'b0;
                if (enable) begin
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (!enable) begin
                    state_d    = ST_IDLE;
                    wrap_cnt_d = WRAP_ZERO;
                end else if (complete_s) begin
                    state_d       = ST_PENDING;
                    wrap_cnt_d    = WRAP_ZERO;
                    event_count_d = event_count_q + EVT_ONE;
                    irq_req_d     = 1'b1;
                end else if (wrap_s) begin
                    wrap_cnt_d = wrap_cnt_q + WRAP_ONE;
                end else begin
                    wrap_cnt_d = wrap_cnt_q;
                end
            end
            ST_PENDING: begin
                irq_req_d = 1'b1;
                if (complete_s) begin
                    wrap_cnt_d    = WRAP_ZERO;
                    event_count_d = event_count_q + EVT_ONE;
                end else if (enable && wrap_s) begin
                    wrap_cnt_d = wrap_cnt_q + WRAP_ONE;
                end else begin
                    wrap_cnt_d = wrap_cnt_q;
                end
                // An ack coinciding with a fresh completion is consumed by the new event.
                if (irq_ack) begin
                    if (!complete_s) begin
                        irq_req_d = 1'b0;
                        if (enable) begin
                            state_d = ST_ARMED;
                        end else begin
                            state_d    = ST_IDLE;
                            wrap_cnt_d = WRAP_ZERO;
                        end
                    end else begin
                        state_d = ST_PENDING;
                    end
                end else if (complete_s) begin
                    ovr_set_s = 1'b1;
                end else begin
                    ovr_set_s = 1'b0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                wrap_cnt_d = WRAP_ZERO;
                irq_req_d  = 1'b0;
            end
        endcase

        if (ovr_set_s) begin
            overrun_d = 1'b1;
        end else if (clear_ovr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    assign irq_req     = irq_req_q;
    assign overrun     = overrun_q;
    assign wrap_cnt    = wrap_cnt_q;
    assign event_count = event_count_q;
    assign state       = state_q;

endmodule
